// File: rtl/sw_input_pkg.sv
// Shared constants and types for the slide-switch input controller.
// Register map, edge-type encodings and debounce counter width.
package sw_input_pkg;

  localparam int DB_CNT_W = 16;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_DBLIMIT = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  typedef enum logic {
    DB_STABLE,
    DB_COUNTING
  } db_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, debounce counter, stable flop.
// Ports: clk, reset_n, din (raw pin), db_limit, stable (debounced).
module sw_debounce_bit
  import sw_input_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                din,
  input  logic [DB_CNT_W-1:0] db_limit,
  output logic                stable
);

  logic                sync_q1;
  logic                sync_q2;
  db_state_e           state_q;
  db_state_e           state_d;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;
  logic                stable_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      stable  <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stable  <= stable_nxt;
    end
  end

  // The >= compare lets a lowered limit end a count on the next cycle
  // and keeps the counter from ever passing the limit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stable_nxt = stable;
    if (db_limit == '0) begin
      state_d    = DB_STABLE;
      cnt_d      = '0;
      stable_nxt = sync_q2;
    end else begin
      unique case (state_q)
        DB_STABLE: begin
          if (sync_q2 != stable) begin
            state_d = DB_COUNTING;
            cnt_d   = DB_CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        DB_COUNTING: begin
          if (sync_q2 == stable) begin
            state_d = DB_STABLE;
            cnt_d   = '0;
          end else if (cnt_q >= db_limit) begin
            state_d    = DB_STABLE;
            cnt_d      = '0;
            stable_nxt = sync_q2;
          end else begin
            cnt_d = cnt_q + DB_CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sw_input_ctrl.sv
// Avalon-MM slave for the slide-switch bank: debounce, edge capture, irq.
// Ports: clk, reset_n, Avalon slave (address/chipselect/write_n/
// writedata/readdata), in_port (raw switches), irq (level).
module sw_input_ctrl
  import sw_input_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter logic [15:0] DB_RESET  = 16'd50000,
  parameter int          EDGE_TYPE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic                wr_en;
  logic                rd_en;
  logic [WIDTH-1:0]    stable;
  logic [WIDTH-1:0]    stable_q;
  logic [WIDTH-1:0]    irq_mask;
  logic [WIDTH-1:0]    edge_cap;
  logic [WIDTH-1:0]    edge_det;
  logic [WIDTH-1:0]    w1c;
  logic [DB_CNT_W-1:0] db_limit;
  logic [31:0]         rd_mux;
  logic                unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & write_n;
  assign unused_wd = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    sw_debounce_bit u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .din      (in_port[i]),
      .db_limit (db_limit),
      .stable   (stable[i])
    );
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = stable & ~stable_q;
      EDGE_FALL: edge_det = ~stable & stable_q;
      default:   edge_det = stable ^ stable_q;
    endcase
  end

  always_comb begin
    w1c = '0;
    if (wr_en && address == ADDR_EDGECAP)
      w1c = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0]    = stable;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0]    = irq_mask;
      ADDR_DBLIMIT: rd_mux[DB_CNT_W-1:0] = db_limit;
      default:      rd_mux[WIDTH-1:0]    = edge_cap;
    endcase
  end

  // A new edge is ORed in after the clear, so it wins over a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_q <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      db_limit <= DB_RESET;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      stable_q <= stable;
      edge_cap <= (edge_cap & ~w1c) | edge_det;
      irq      <= |(edge_cap & irq_mask);
      if (rd_en)
        readdata <= rd_mux;
      if (wr_en) begin
        if (address == ADDR_IRQMASK)
          irq_mask <= writedata[WIDTH-1:0];
        if (address == ADDR_DBLIMIT)
          db_limit <= writedata[DB_CNT_W-1:0];
      end
    end
  end

endmodule

// File: doc/sw_input_ctrl.md
Name: sw_input_ctrl

Overview:
Avalon-MM slave controller for the board slide-switch input bank. It sits between the raw switch pins and the Nios II data master. Per bit, it synchronises, debounces, detects edges, captures edges and raises an interrupt. Software sees a debounced data register, an IRQ mask, a programmable debounce limit and a write-1-to-clear edge-capture register, so it no longer needs to poll a raw PIO.

Parameters:
WIDTH, 4, number of switch inputs (1..32)
DB_RESET, 16'd50000, reset value of the debounce limit register (1 ms at 50 MHz)
EDGE_TYPE, 2, edges captured: 0 = rising, 1 = falling, 2 = any

Ports:
clk  in  1  system clock; all logic on the rising edge
reset_n  in  1  synchronous, active-low reset, sampled on the clk rising edge
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
in_port  in  WIDTH  raw asynchronous switch inputs
irq  out  1  level interrupt to the Nios II

Behaviour:
- Register map (word addresses):
  - 0 DATA: read-only; debounced state, bits [WIDTH-1:0].
  - 1 IRQMASK: read/write, bits [WIDTH-1:0].
  - 2 DBLIMIT: read/write, bits [15:0].
  - 3 EDGECAP: read; write-1-to-clear per bit.
  - Unused upper bits read as 0. Writes to DATA are ignored.
- Reset (reset_n = 0 at a clk edge):
  - readdata = 0, irq = 0.
  - IRQMASK = 0, EDGECAP = 0, DBLIMIT = DB_RESET.
  - Sync flops = 0, stable = 0, all counters = 0.
  - Reset asserted mid-debounce aborts the count with no edge recorded.
- Synchroniser: two flops per bit. sync_i is in_port_i delayed 2 cycles.
- Debounce, per bit, with states STABLE and COUNTING:
  - STABLE: if sync_i == stable_i, the counter holds at 0. Otherwise go to COUNTING with cnt = 1.
  - COUNTING: if sync_i == stable_i (bounce), return to STABLE with cnt = 0.
  - COUNTING: else if cnt >= DBLIMIT, set stable_i = sync_i, cnt = 0, go to STABLE.
  - COUNTING: else cnt++.
  - The >= compare means a lowered DBLIMIT is honoured on the next cycle. The counter is 16 bits and cannot wrap, because cnt never exceeds DBLIMIT.
  - DBLIMIT = 0 is bypass: stable_i follows sync_i every cycle.
- Latency:
  - An in_port change at edge T with DBLIMIT = L >= 1 reaches DATA (stable) at edge T+2+L, provided the input holds.
  - Any reversion before that point restarts the qualification.
- Edge detect: compare stable against stable_d (1-cycle delayed), gated by EDGE_TYPE. The EDGECAP bit sets at edge T+3+L.
- EDGECAP:
  - A bit sets on a detected edge and stays set until software writes 1 to it.
  - If an edge and a W1C on the same bit land in the same cycle, the set wins.
  - Writing 0 has no effect.
- irq: registered; irq = |(EDGECAP & IRQMASK), updated one cycle after either term changes.
- Avalon reads:
  - Latency 1: readdata is loaded on the edge where chipselect = 1 and write_n = 1.
  - Otherwise readdata holds its value.
  - Reads have no side effects, including reads of EDGECAP.
- Avalon writes: take effect at the edge where chipselect = 1 and write_n = 0. The new value is visible to logic on the following cycle.
- Power-up: switches already high at reset produce a rising edge, which is captured into EDGECAP after the first debounce interval. Software clears EDGECAP after setting DBLIMIT.

Decomposition:
- Package sw_input_pkg holds:
  - register address constants ADDR_DATA = 0, ADDR_IRQMASK = 1, ADDR_DBLIMIT = 2, ADDR_EDGECAP = 3
  - EDGE_TYPE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY
  - DB_CNT_W = 16
- Sub-module sw_debounce_bit: synchroniser, counter and stable flop for one bit, instantiated WIDTH times in a generate loop.
- The top level keeps the register file, edge capture, irq and read mux.

Test Plan:
1. Reset with in_port = 4'hF -> readdata, irq and EDGECAP are 0 and DBLIMIT reads 50000. After 50002 cycles DATA reads 4'hF and EDGECAP reads 4'hF.
2. DBLIMIT = 4; pulse in_port[0] high for 3 cycles -> DATA stays 0 and EDGECAP stays 0. Hold it high instead -> DATA[0] = 1 at T+6, EDGECAP[0] = 1 at T+7.
3. IRQMASK = 4'h1; rising edge on bit 2 -> EDGECAP = 4'h4 with irq = 0. Then rising edge on bit 0 -> irq = 1 one cycle after EDGECAP[0] sets.
4. EDGECAP = 4'h1, irq = 1; write EDGECAP = 4'h1 -> EDGECAP = 0 and irq = 0 one cycle later. Repeat with a new bit-0 edge landing in the same cycle as the write -> EDGECAP[0] stays 1.
5. DBLIMIT = 0, EDGE_TYPE = 1 build; toggle in_port[3] high then low -> DATA tracks with 2-cycle latency and only the falling edge sets EDGECAP[3].
6. DBLIMIT = 100, bit 1 counting at cnt = 50; write DBLIMIT = 10 -> DATA[1] updates on the next cycle. Back-to-back reads of addresses 0-3 return each value one cycle after its address.
